// File: rtl/tl_traffic_gen.sv
// tl_traffic_gen: street-side vehicle model that pairs with a traffic-light
// controller. Keeps a waiting-car queue per street (A, B), adds arrivals,
// removes one car every DEP_GAP cycles while that street is green, and
// reports car presence (Ta/Tb) back to the controller.
// Optional feature macro: SAFETY_CHK_EN enables the sticky light-protocol
// error flag (err); without it err is tied low.
module tl_traffic_gen #(
  parameter int QW      = 3,
  parameter int MAX_Q   = 7,
  parameter int DEP_GAP = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          arr_a,
  input  logic          arr_b,
  input  logic [1:0]    La,
  input  logic [1:0]    Lb,
  output logic          Ta,
  output logic          Tb,
  output logic [QW-1:0] cnt_a,
  output logic [QW-1:0] cnt_b,
  output logic          dep_a,
  output logic          dep_b,
  output logic          drop_a,
  output logic          drop_b,
  output logic          err
);

  // Gap counter is at least QW bits, widened if DEP_GAP-1 would not fit.
  localparam int W_DG = $clog2(DEP_GAP + 1);
  localparam int GW   = (QW > W_DG) ? QW : W_DG;

  localparam logic [GW-1:0] GAP_LAST = GW'(DEP_GAP - 1);
  localparam logic [QW-1:0] CNT_MAX  = QW'(MAX_Q);
  localparam logic [QW-1:0] CNT_ZERO = {QW{1'b0}};
  localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};
  localparam logic [1:0]    L_GREEN  = 2'b00;

  // Index 0 is street A, index 1 is street B.
  logic [QW-1:0] r_cnt [2];
  logic [GW-1:0] r_gap [2];
  logic [1:0]    r_dep;
  logic [1:0]    r_drop;
  logic [1:0]    r_t;

  logic [1:0]    w_arr;
  logic [1:0]    w_light [2];
  logic [1:0]    w_active;
  logic [1:0]    w_dep;
  logic [1:0]    w_drop;
  logic [1:0]    w_full;
  logic [1:0]    w_t_nxt;
  logic [QW-1:0] w_cnt_nxt [2];
  logic [GW-1:0] w_gap_nxt [2];

  // Per-street next-state: departure pacing, arrivals, and overflow drops.
  // A 2'b11 light never matches green, so it clears the gap and blocks departures.
  always_comb begin
    w_arr      = {arr_b, arr_a};
    w_light[0] = La;
    w_light[1] = Lb;
    w_active   = 2'b00;
    w_dep      = 2'b00;
    w_drop     = 2'b00;
    w_full     = 2'b00;
    w_t_nxt    = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      w_gap_nxt[i] = GAP_ZERO;
      w_active[i]  = (w_light[i] == L_GREEN) && (r_cnt[i] != CNT_ZERO);
      w_dep[i]     = w_active[i] && (r_gap[i] == GAP_LAST);
      w_full[i]    = (r_cnt[i] == CNT_MAX);
      // A departure frees a slot in the same cycle, so a full queue accepts it.
      w_drop[i]    = w_arr[i] && w_full[i] && !w_dep[i];

      if (w_dep[i] && !w_arr[i]) begin
        w_cnt_nxt[i] = r_cnt[i] - QW'(1);
      end else if (!w_dep[i] && w_arr[i] && !w_full[i]) begin
        w_cnt_nxt[i] = r_cnt[i] + QW'(1);
      end else begin
        w_cnt_nxt[i] = r_cnt[i];
      end

      if (w_active[i] && !w_dep[i]) begin
        w_gap_nxt[i] = r_gap[i] + GW'(1);
      end else begin
        w_gap_nxt[i] = GAP_ZERO;
      end

      w_t_nxt[i] = (w_cnt_nxt[i] != CNT_ZERO);
    end
  end

  // Queue, gap and pulse registers; async reset flushes everything.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= CNT_ZERO;
        r_gap[i] <= GAP_ZERO;
      end
      r_dep  <= 2'b00;
      r_drop <= 2'b00;
      r_t    <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
        r_gap[i] <= w_gap_nxt[i];
      end
      r_dep  <= w_dep;
      r_drop <= w_drop;
      r_t    <= w_t_nxt;
    end
  end

`ifdef SAFETY_CHK_EN
  logic r_err;
  logic w_conflict;

  // Protocol violation: both streets non-red at once, or any illegal encoding.
  always_comb begin
    w_conflict = ((La != 2'b10) && (Lb != 2'b10)) || (La == 2'b11) || (Lb == 2'b11);
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= r_err | w_conflict;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign cnt_a  = r_cnt[0];
  assign cnt_b  = r_cnt[1];
  assign Ta     = r_t[0];
  assign Tb     = r_t[1];
  assign dep_a  = r_dep[0];
  assign dep_b  = r_dep[1];
  assign drop_a = r_drop[0];
  assign drop_b = r_drop[1];

endmodule
